wb_arbiter: RTL and testbench
=============================

# wb_arbiter

Write-back arbiter that owns the register-file write port. Merges single-cycle ALU results with variable-latency load/store-unit results and drives one registered write per cycle (`wr_en_o`, `rd_addr_o`, `rd_data_o`). LSU results are buffered in a small FIFO. The block reports hazards on buffered destinations to decode and forces the ALU to yield when the FIFO is starved. It sits between the execute/LSU stages and the register file.

## Interface
- `DEPTH`, default 2: LSU result FIFO depth; power of two, ≥ 2.
- `STARVE_MAX`, default 4: consecutive blocked cycles of a non-empty FIFO before the ALU is forced to yield; ≥ 1.

Ports:
- `clk`  in  1  clock; all state updates on the rising edge.
- `rst_n`  in  1  reset; asynchronous assertion, active-low.
- `alu_valid_i`  in  1  ALU result present this cycle; no backpressure.
- `alu_rd_addr_i`  in  5  ALU destination register.
- `alu_rd_data_i`  in  32  ALU result.
- `alu_stall_o`  out  1  registered; ALU must hold its result this cycle.
- `lsu_valid_i`  in  1  LSU result offered.
- `lsu_ready_o`  out  1  FIFO can accept the LSU result.
- `lsu_rd_addr_i`  in  5  LSU destination register.
- `lsu_rd_data_i`  in  32  LSU result.
- `rs1_addr_i`, `rs2_addr_i`  in  5  decode source registers, used for the hazard check.
- `hazard_o`  out  1  a FIFO entry targets a non-zero `rs1`/`rs2`.
- `wr_en_o`  out  1  registered register-file write enable.
- `rd_addr_o`  out  5  registered write address.
- `rd_data_o`  out  32  registered write data.

## Operation
- LSU handshake: an LSU result is accepted when `lsu_valid_i & lsu_ready_o` at a rising edge.
- `lsu_ready_o = rst_n & (count != DEPTH)`. It depends on the stored count only; a pop in the same cycle does not raise it.
- Accepted LSU result with `lsu_rd_addr_i == 0`: the handshake completes and nothing is pushed.
- Source select each cycle, first match wins:
  1. `alu_stall_o == 1` and FIFO non-empty: pop the FIFO head; ALU inputs are ignored.
  2. `alu_valid_i` and `alu_rd_addr_i != 0`: ALU result.
  3. FIFO non-empty: pop the FIFO head.
  4. Otherwise no write.
- ALU result with `alu_rd_addr_i == 0` is discarded and does not block a FIFO pop.
- Output register on every edge: `wr_en_o <= selected`. `rd_addr_o`/`rd_data_o` load only when a source is selected and otherwise hold their value.
- Push and pop in the same cycle are both performed; `count` is unchanged.
- FIFO order is strict FIFO; LSU results are never reordered among themselves.
- Starvation counter `starve_cnt`:
  - Cleared when the FIFO is empty or a pop occurs.
  - Otherwise increments, saturating at `STARVE_MAX`.
  - `alu_stall_o <= (next starve_cnt == STARVE_MAX)`.
  - Because the pop in the stalled cycle clears the counter, `alu_stall_o` is high for exactly one cycle.
- `hazard_o` is combinational: the OR over valid FIFO entries of `(entry.rd == rs1_addr_i && rs1_addr_i != 0) || (entry.rd == rs2_addr_i && rs2_addr_i != 0)`. The output register is excluded because the register file forwards same-cycle writes.

## Timing
- Reset (`rst_n` low, asynchronous):
  - FIFO empty, `starve_cnt = 0`.
  - `wr_en_o = 0`, `rd_addr_o = 0`, `rd_data_o = 0`, `alu_stall_o = 0`.
  - `lsu_ready_o = 0`, `hazard_o = 0`.
- Reset mid-operation discards all buffered results. After `rst_n` rises, `lsu_ready_o = 1` in the first cycle.
- ALU latency: result in cycle t produces `wr_en_o = 1` in cycle t+1.
- LSU latency: accepted at the edge ending cycle t. With no ALU contention in t+1, `wr_en_o = 1` in t+2. Each contended cycle adds one cycle of latency.
- Worst-case LSU wait at the FIFO head under continuous ALU traffic: `STARVE_MAX + 1` cycles.
- Full FIFO: `lsu_ready_o = 0` for the whole cycle, even if a pop occurs in that cycle. The LSU must hold valid, address and data until accepted.

## Test plan
- Reset: assert `rst_n = 0` mid-stream with 2 entries buffered → all outputs 0 immediately. After release: `lsu_ready_o = 1`, `hazard_o = 0`, no stale write ever appears.
- ALU only: ALU writes x5 = 0x1234 in cycle t → `wr_en_o = 1`, `rd_addr_o = 5`, `rd_data_o = 0x1234` in t+1. An ALU write with rd = 0 → `wr_en_o = 0`.
- LSU fill and backpressure (`DEPTH = 2`):
  - Three back-to-back LSU results x1 = 0xA, x2 = 0xB, x3 = 0xC while the ALU is busy writing x7 → `lsu_ready_o` drops after two pushes.
  - Once the ALU goes idle, writes x1, x2, x3 appear in order; x3 is accepted one cycle after the first pop.
- Starvation (`STARVE_MAX = 4`): LSU x9 = 0x99 buffered, ALU valid every cycle with rd = 4 → `alu_stall_o = 1` after 4 blocked cycles. That cycle writes x9 = 0x99 and ignores the ALU; `alu_stall_o = 0` the next cycle.
- Hazard: x6 buffered.
  - `rs1 = 6` → `hazard_o = 1`.
  - `rs2 = 6` → `hazard_o = 1`.
  - `rs1 = rs2 = 0` → `hazard_o = 0`.
  - `hazard_o` drops the cycle after x6 is popped.
- Simultaneous push/pop at `count = 1`: count stays 1 and `lsu_ready_o` stays 1 throughout.

Source files
------------

// File: rtl/wb_arbiter_if.sv
// wb_arbiter_if: bundles the write-back arbiter's execute/LSU/decode-side
// signals and its register-file write port.
//   slave  : arbiter side (inputs *_i, outputs *_o)
//   master : surrounding pipeline / testbench side
// Signals: ALU result (valid/addr/data, stall back), LSU result
// (valid/ready/addr/data), decode sources rs1/rs2 with hazard back,
// and the registered write port wr_en/rd_addr/rd_data.
interface wb_arbiter_if;
    logic        alu_valid_i;
    logic [4:0]  alu_rd_addr_i;
    logic [31:0] alu_rd_data_i;
    logic        alu_stall_o;
    logic        lsu_valid_i;
    logic        lsu_ready_o;
    logic [4:0]  lsu_rd_addr_i;
    logic [31:0] lsu_rd_data_i;
    logic [4:0]  rs1_addr_i;
    logic [4:0]  rs2_addr_i;
    logic        hazard_o;
    logic        wr_en_o;
    logic [4:0]  rd_addr_o;
    logic [31:0] rd_data_o;

    modport slave (
        input  alu_valid_i, alu_rd_addr_i, alu_rd_data_i,
        input  lsu_valid_i, lsu_rd_addr_i, lsu_rd_data_i,
        input  rs1_addr_i, rs2_addr_i,
        output alu_stall_o, lsu_ready_o, hazard_o,
        output wr_en_o, rd_addr_o, rd_data_o
    );

    modport master (
        output alu_valid_i, alu_rd_addr_i, alu_rd_data_i,
        output lsu_valid_i, lsu_rd_addr_i, lsu_rd_data_i,
        output rs1_addr_i, rs2_addr_i,
        input  alu_stall_o, lsu_ready_o, hazard_o,
        input  wr_en_o, rd_addr_o, rd_data_o
    );
endinterface

// File: rtl/wb_arbiter.sv
// wb_arbiter: owns the register-file write port. Merges single-cycle ALU
// results with buffered LSU results and issues one registered write per cycle.
// Ports:
//   clk    rising-edge clock
//   rst_n  asynchronous active-low reset
//   bus    wb_arbiter_if.slave (ALU/LSU results, decode sources, write port)
// Parameters:
//   DEPTH       LSU FIFO depth (power of two, >= 2)
//   STARVE_MAX  blocked cycles of a non-empty FIFO before the ALU must yield
module wb_arbiter #(
    parameter int DEPTH      = 2,
    parameter int STARVE_MAX = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    wb_arbiter_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int SW = $clog2(STARVE_MAX + 1);
    localparam logic [SW-1:0] STARVE_LIM = SW'(STARVE_MAX);

    logic [4:0]       fifo_addr_q [DEPTH];
    logic [31:0]      fifo_data_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [SW-1:0]    starve_cnt_q, starve_cnt_d;
    logic             alu_stall_q, alu_stall_d;
    logic             wr_en_q, wr_en_d;
    logic [4:0]       rd_addr_q, rd_addr_d;
    logic [31:0]      rd_data_q, rd_data_d;

    logic fifo_empty, fifo_full, lsu_ready, push, pop, sel_alu, hazard;

    // A slot is occupied exactly when its valid bit is set, so full/empty
    // fall out of the valid vector without a separate count.
    assign fifo_empty = ~|valid_q;
    assign fifo_full  = &valid_q;
    assign lsu_ready  = rst_n & ~fifo_full;
    // rd == 0 results complete the handshake but are dropped.
    assign push = bus.lsu_valid_i & lsu_ready & (bus.lsu_rd_addr_i != 5'd0);

    always_comb begin
        pop       = 1'b0;
        sel_alu   = 1'b0;
        if (alu_stall_q && !fifo_empty) begin
            pop = 1'b1;
        end else if (bus.alu_valid_i && bus.alu_rd_addr_i != 5'd0) begin
            sel_alu = 1'b1;
        end else if (!fifo_empty) begin
            pop = 1'b1;
        end

        wr_en_d   = pop | sel_alu;
        rd_addr_d = rd_addr_q;
        rd_data_d = rd_data_q;
        if (sel_alu) begin
            rd_addr_d = bus.alu_rd_addr_i;
            rd_data_d = bus.alu_rd_data_i;
        end else if (pop) begin
            rd_addr_d = fifo_addr_q[rd_ptr_q];
            rd_data_d = fifo_data_q[rd_ptr_q];
        end

        valid_d  = valid_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
        if (pop) begin
            valid_d[rd_ptr_q] = 1'b0;
            rd_ptr_d          = rd_ptr_q + PW'(1);
        end
        if (push) begin
            valid_d[wr_ptr_q] = 1'b1;
            wr_ptr_d          = wr_ptr_q + PW'(1);
        end

        // A pop clears the counter, so the forced-yield stall lasts one cycle.
        if (fifo_empty || pop) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q == STARVE_LIM) begin
            starve_cnt_d = starve_cnt_q;
        end else begin
            starve_cnt_d = starve_cnt_q + SW'(1);
        end
        alu_stall_d = (starve_cnt_d == STARVE_LIM);
    end

    // The output register is not checked: the register file forwards
    // same-cycle writes, so only still-buffered results are hazards.
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < DEPTH; i++) begin
            if (valid_q[i] &&
                ((fifo_addr_q[i] == bus.rs1_addr_i && bus.rs1_addr_i != 5'd0) ||
                 (fifo_addr_q[i] == bus.rs2_addr_i && bus.rs2_addr_i != 5'd0))) begin
                hazard = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q      <= '0;
            rd_ptr_q     <= '0;
            wr_ptr_q     <= '0;
            starve_cnt_q <= '0;
            alu_stall_q  <= 1'b0;
            wr_en_q      <= 1'b0;
            rd_addr_q    <= 5'd0;
            rd_data_q    <= 32'd0;
        end else begin
            valid_q      <= valid_d;
            rd_ptr_q     <= rd_ptr_d;
            wr_ptr_q     <= wr_ptr_d;
            starve_cnt_q <= starve_cnt_d;
            alu_stall_q  <= alu_stall_d;
            wr_en_q      <= wr_en_d;
            rd_addr_q    <= rd_addr_d;
            rd_data_q    <= rd_data_d;
        end
    end

    // Storage is qualified by valid_q, so it needs no reset.
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_addr_q[wr_ptr_q] <= bus.lsu_rd_addr_i;
            fifo_data_q[wr_ptr_q] <= bus.lsu_rd_data_i;
        end
    end

    assign bus.lsu_ready_o = lsu_ready;
    assign bus.hazard_o    = hazard;
    assign bus.alu_stall_o = alu_stall_q;
    assign bus.wr_en_o     = wr_en_q;
    assign bus.rd_addr_o   = rd_addr_q;
    assign bus.rd_data_o   = rd_data_q;
endmodule

// File: tb/tb_wb_arbiter.sv
// tb_wb_arbiter: directed, table-driven bench for wb_arbiter (DEPTH=2,
// STARVE_MAX=4) plus a hand-written mid-stream reset sequence.
module tb_wb_arbiter;
    logic clk;
    logic rst_n;
    wb_arbiter_if bus ();

    wb_arbiter #(.DEPTH(2), .STARVE_MAX(4)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        alu_v;
        logic [4:0]  alu_a;
        logic [31:0] alu_d;
        logic        lsu_v;
        logic [4:0]  lsu_a;
        logic [31:0] lsu_d;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic        e_ready;  // before the edge
        logic        e_haz;    // before the edge
        logic        e_wr;     // after the edge
        logic [4:0]  e_a;      // after the edge, only when e_wr
        logic [31:0] e_d;
        logic        e_stall;  // after the edge
    } vec_t;

    vec_t vecs[$];
    int n_pass = 0;
    int n_total = 0;
    logic [4:0]  hold_a;
    logic [31:0] hold_d;

    function automatic vec_t mk(logic av, logic [4:0] aa, logic [31:0] ad,
                                logic lv, logic [4:0] la, logic [31:0] ld,
                                logic [4:0] r1, logic [4:0] r2,
                                logic er, logic eh, logic ew,
                                logic [4:0] ea, logic [31:0] ed, logic es);
        vec_t v;
        v.alu_v = av; v.alu_a = aa; v.alu_d = ad;
        v.lsu_v = lv; v.lsu_a = la; v.lsu_d = ld;
        v.rs1 = r1; v.rs2 = r2;
        v.e_ready = er; v.e_haz = eh; v.e_wr = ew;
        v.e_a = ea; v.e_d = ed; v.e_stall = es;
        return v;
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s: got %h expected %h", name, act, exp);
        else
            n_pass++;
    endtask

    task automatic drive(vec_t v);
        bus.alu_valid_i   = v.alu_v;
        bus.alu_rd_addr_i = v.alu_a;
        bus.alu_rd_data_i = v.alu_d;
        bus.lsu_valid_i   = v.lsu_v;
        bus.lsu_rd_addr_i = v.lsu_a;
        bus.lsu_rd_data_i = v.lsu_d;
        bus.rs1_addr_i    = v.rs1;
        bus.rs2_addr_i    = v.rs2;
    endtask

    // Called at posedge+1: drive, check combinational outputs, cross the
    // edge, check registered outputs.
    task automatic run_row(int idx, vec_t v);
        drive(v);
        #1;
        chk($sformatf("row%0d lsu_ready", idx), {31'd0, bus.lsu_ready_o}, {31'd0, v.e_ready});
        chk($sformatf("row%0d hazard", idx), {31'd0, bus.hazard_o}, {31'd0, v.e_haz});
        @(posedge clk);
        #1;
        if (v.e_wr) begin
            hold_a = v.e_a;
            hold_d = v.e_d;
        end
        chk($sformatf("row%0d wr_en", idx), {31'd0, bus.wr_en_o}, {31'd0, v.e_wr});
        chk($sformatf("row%0d rd_addr", idx), {27'd0, bus.rd_addr_o}, {27'd0, hold_a});
        chk($sformatf("row%0d rd_data", idx), bus.rd_data_o, hold_d);
        chk($sformatf("row%0d alu_stall", idx), {31'd0, bus.alu_stall_o}, {31'd0, v.e_stall});
    endtask

    task automatic check_all_zero(string tag);
        chk({tag, " wr_en"}, {31'd0, bus.wr_en_o}, 32'd0);
        chk({tag, " rd_addr"}, {27'd0, bus.rd_addr_o}, 32'd0);
        chk({tag, " rd_data"}, bus.rd_data_o, 32'd0);
        chk({tag, " alu_stall"}, {31'd0, bus.alu_stall_o}, 32'd0);
        chk({tag, " lsu_ready"}, {31'd0, bus.lsu_ready_o}, 32'd0);
        chk({tag, " hazard"}, {31'd0, bus.hazard_o}, 32'd0);
    endtask

    initial begin
        #20000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        //        alu_v a   d          lsu_v a   d       rs1 rs2  rdy haz wr a   d          stall
        // ALU only
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,      0, 0,  1, 0, 0, 0, 0,          0));
        vecs.push_back(mk(1, 5, 32'h1234,     0, 0, 0,      0, 0,  1, 0, 1, 5, 32'h1234,   0));
        vecs.push_back(mk(1, 0, 32'hDEAD,     0, 0, 0,      0, 0,  1, 0, 0, 0, 0,          0));
        // Fill and backpressure, ALU busy on x7
        vecs.push_back(mk(1, 7, 32'h70,       1, 1, 32'hA,  0, 0,  1, 0, 1, 7, 32'h70,     0));
        vecs.push_back(mk(1, 7, 32'h71,       1, 2, 32'hB,  0, 0,  1, 0, 1, 7, 32'h71,     0));
        vecs.push_back(mk(1, 7, 32'h72,       1, 3, 32'hC,  0, 0,  0, 0, 1, 7, 32'h72,     0));
        vecs.push_back(mk(0, 0, 0,            1, 3, 32'hC,  0, 0,  0, 0, 1, 1, 32'hA,      0));
        vecs.push_back(mk(0, 0, 0,            1, 3, 32'hC,  0, 0,  1, 0, 1, 2, 32'hB,      0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,      0, 0,  1, 0, 1, 3, 32'hC,      0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,      0, 0,  1, 0, 0, 0, 0,          0));
        // Simultaneous push/pop at one entry
        vecs.push_back(mk(0, 0, 0,            1, 10, 32'h100, 0, 0, 1, 0, 0, 0, 0,         0));
        vecs.push_back(mk(0, 0, 0,            1, 11, 32'h101, 0, 0, 1, 0, 1, 10, 32'h100,  0));
        vecs.push_back(mk(0, 0, 0,            1, 12, 32'h102, 0, 0, 1, 0, 1, 11, 32'h101,  0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,      0, 0,  1, 0, 1, 12, 32'h102,   0));
        // Hazard on buffered x6
        vecs.push_back(mk(1, 8, 32'h80,       1, 6, 32'h66, 0, 0,  1, 0, 1, 8, 32'h80,     0));
        vecs.push_back(mk(1, 8, 32'h81,       0, 0, 0,      6, 0,  1, 1, 1, 8, 32'h81,     0));
        vecs.push_back(mk(1, 8, 32'h82,       0, 0, 0,      0, 6,  1, 1, 1, 8, 32'h82,     0));
        vecs.push_back(mk(1, 8, 32'h83,       0, 0, 0,      0, 0,  1, 0, 1, 8, 32'h83,     0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,      6, 0,  1, 1, 1, 6, 32'h66,     0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,      6, 0,  1, 0, 0, 0, 0,          0));
        // Starvation: x9 buffered, ALU writes x4 every cycle
        vecs.push_back(mk(1, 4, 32'h40,       1, 9, 32'h99, 0, 0,  1, 0, 1, 4, 32'h40,     0));
        vecs.push_back(mk(1, 4, 32'h41,       0, 0, 0,      0, 0,  1, 0, 1, 4, 32'h41,     0));
        vecs.push_back(mk(1, 4, 32'h42,       0, 0, 0,      0, 9,  1, 1, 1, 4, 32'h42,     0));
        vecs.push_back(mk(1, 4, 32'h43,       0, 0, 0,      0, 0,  1, 0, 1, 4, 32'h43,     0));
        vecs.push_back(mk(1, 4, 32'h44,       0, 0, 0,      0, 0,  1, 0, 1, 4, 32'h44,     1));
        vecs.push_back(mk(1, 4, 32'h45,       0, 0, 0,      0, 0,  1, 0, 1, 9, 32'h99,     0));
        vecs.push_back(mk(1, 4, 32'h45,       0, 0, 0,      0, 0,  1, 0, 1, 4, 32'h45,     0));
        // LSU result to x0: handshake only, nothing buffered
        vecs.push_back(mk(0, 0, 0,            1, 0, 32'h77, 0, 0,  1, 0, 0, 0, 0,          0));
        vecs.push_back(mk(0, 0, 0,            0, 0, 0,      0, 0,  1, 0, 0, 0, 0,          0));

        hold_a = 5'd0;
        hold_d = 32'd0;
        rst_n = 1'b0;
        drive(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("init_reset");
        rst_n = 1'b1;

        for (int i = 0; i < vecs.size(); i++)
            run_row(i, vecs[i]);

        // Mid-stream reset with two LSU entries buffered behind ALU traffic.
        drive(mk(1, 3, 32'h30, 1, 1, 32'h11, 1, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        drive(mk(1, 3, 32'h31, 1, 2, 32'h22, 1, 0, 0, 0, 0, 0, 0, 0));
        @(posedge clk); #1;
        drive(mk(1, 3, 32'h32, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        #1;
        chk("pre_reset hazard", {31'd0, bus.hazard_o}, 32'd1);
        chk("pre_reset lsu_ready", {31'd0, bus.lsu_ready_o}, 32'd0);
        chk("pre_reset wr_en", {31'd0, bus.wr_en_o}, 32'd1);
        rst_n = 1'b0;
        #1;
        check_all_zero("mid_reset");
        drive(mk(0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0));
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("held_reset");
        rst_n = 1'b1;
        #1;
        chk("post_reset lsu_ready", {31'd0, bus.lsu_ready_o}, 32'd1);
        chk("post_reset hazard", {31'd0, bus.hazard_o}, 32'd0);
        for (int c = 0; c < 3; c++) begin
            @(posedge clk); #1;
            chk($sformatf("post_reset wr_en c%0d", c), {31'd0, bus.wr_en_o}, 32'd0);
            chk($sformatf("post_reset hazard c%0d", c), {31'd0, bus.hazard_o}, 32'd0);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
